xyz_peppergray_potato1_main: RTL and testbench

Control unit of the Potato-1 Brainfuck-style CPU. Each cycle it decodes a 4-bit instruction fetched externally from program memory at the current program counter. It drives one-hot strobes that move the external program counter, data pointer and cell value, or start an I/O transfer. It resolves `[`/`]` loops internally with a nesting-depth counter, stepping the external PC forward or backward until the matching bracket is reached. All I/O is packed into 8-bit `io_in`/`io_out` buses for the TinyTapeout harness.

---
 rtl/xyz_peppergray_potato1_main.sv | 174 +++++++++++++++++
 tb/tb_xyz_peppergray_potato1_main.sv | 124 ++++++++++++
 2 files changed

// File: rtl/xyz_peppergray_potato1_main.sv
// xyz_peppergray_potato1_main
//
// Control unit of the Potato-1 Brainfuck-style CPU. Each cycle it decodes the
// 4-bit instruction at the current external program counter and drives one-hot
// strobes that step the program counter, data pointer and cell value, or that
// start an I/O transfer. Loop brackets are resolved internally: a nesting-depth
// counter tracks brackets while the PC is walked forward or backward to the
// matching bracket, one instruction per cycle.
//
// Ports (packed for the TinyTapeout harness):
//   io_in[0]    clock     rising-edge clock
//   io_in[1]    reset     asynchronous, active-high
//   io_in[2]    iowait    external I/O not ready, stall the current I/O opcode
//   io_in[3]    zeroflag  current data cell equals zero
//   io_in[7:4]  instruction opcode at the current PC
//   io_out[0]   pc_inc    io_out[1] pc_dec
//   io_out[2]   x_inc     io_out[3] x_dec
//   io_out[4]   a_inc     io_out[5] a_dec
//   io_out[6]   put       io_out[7] get
//
// Outputs are Mealy: combinational from the registered mode/depth and the
// current inputs, so external units act on them at the next rising edge.

module xyz_peppergray_potato1_main (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  typedef enum logic [1:0] {
    EXEC      = 2'd0,
    SEEK_FWD  = 2'd1,
    SEEK_BACK = 2'd2
  } mode_t;

  localparam logic [3:0] OP_A_INC = 4'h1;
  localparam logic [3:0] OP_A_DEC = 4'h2;
  localparam logic [3:0] OP_X_INC = 4'h3;
  localparam logic [3:0] OP_X_DEC = 4'h4;
  localparam logic [3:0] OP_PUT   = 4'h5;
  localparam logic [3:0] OP_GET   = 4'h6;
  localparam logic [3:0] OP_OPEN  = 4'h7;
  localparam logic [3:0] OP_CLOSE = 4'h8;

  logic       clock;
  logic       reset;
  logic       iowait;
  logic       zeroflag;
  logic [3:0] instruction;

  assign clock       = io_in[0];
  assign reset       = io_in[1];
  assign iowait      = io_in[2];
  assign zeroflag    = io_in[3];
  assign instruction = io_in[7:4];

  mode_t      mode;
  mode_t      next_mode;
  logic [7:0] depth;
  logic [7:0] next_depth;
  logic [7:0] depth_plus;
  logic [7:0] depth_minus;

  logic pc_inc, pc_dec, x_inc, x_dec, a_inc, a_dec, put, get;

  // Depth arithmetic wraps modulo 256; nesting beyond 255 is unsupported.
  assign depth_plus  = depth + 8'd1;
  assign depth_minus = depth - 8'd1;

  // Decode: produce this cycle's strobes and the mode/depth to load at the
  // next edge. A stalled I/O opcode simply withholds pc_inc, which keeps both
  // the PC and the internal state where they are.
  always_comb begin
    next_mode  = mode;
    next_depth = depth;
    pc_inc     = 1'b0;
    pc_dec     = 1'b0;
    x_inc      = 1'b0;
    x_dec      = 1'b0;
    a_inc      = 1'b0;
    a_dec      = 1'b0;
    put        = 1'b0;
    get        = 1'b0;

    case (mode)
      EXEC: begin
        case (instruction)
          OP_A_INC: begin a_inc = 1'b1; pc_inc = 1'b1; end
          OP_A_DEC: begin a_dec = 1'b1; pc_inc = 1'b1; end
          OP_X_INC: begin x_inc = 1'b1; pc_inc = 1'b1; end
          OP_X_DEC: begin x_dec = 1'b1; pc_inc = 1'b1; end
          OP_PUT: begin
            put    = 1'b1;
            pc_inc = ~iowait;
          end
          OP_GET: begin
            get    = 1'b1;
            pc_inc = ~iowait;
          end
          OP_OPEN: begin
            // Taken '[' still steps past itself; the seek starts on the
            // instruction that follows it.
            pc_inc = 1'b1;
            if (zeroflag) begin
              next_depth = 8'd1;
              next_mode  = SEEK_FWD;
            end
          end
          OP_CLOSE: begin
            if (zeroflag) begin
              pc_inc = 1'b1;
            end else begin
              pc_dec     = 1'b1;
              next_depth = 8'd1;
              next_mode  = SEEK_BACK;
            end
          end
          default: pc_inc = 1'b1;
        endcase
      end

      SEEK_FWD: begin
        pc_inc = 1'b1;
        if (instruction == OP_OPEN) begin
          next_depth = depth_plus;
        end else if (instruction == OP_CLOSE) begin
          next_depth = depth_minus;
          if (depth_minus == 8'd0) begin
            next_mode = EXEC;
          end
        end
      end

      SEEK_BACK: begin
        if (instruction == OP_CLOSE) begin
          next_depth = depth_plus;
          pc_dec     = 1'b1;
        end else if (instruction == OP_OPEN) begin
          next_depth = depth_minus;
          // On the matching '[' step forward so execution resumes just
          // after it rather than re-evaluating the bracket.
          if (depth_minus == 8'd0) begin
            pc_inc    = 1'b1;
            next_mode = EXEC;
          end else begin
            pc_dec = 1'b1;
          end
        end else begin
          pc_dec = 1'b1;
        end
      end

      default: begin
        next_mode  = EXEC;
        next_depth = 8'd0;
      end
    endcase
  end

  // Mode and depth registers; reset aborts any seek in progress.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mode  <= EXEC;
      depth <= 8'd0;
    end else begin
      mode  <= next_mode;
      depth <= next_depth;
    end
  end

  // Outputs are forced low for as long as reset is held, independent of clock.
  assign io_out = reset ? 8'h00
                        : {get, put, a_dec, a_inc, x_dec, x_inc, pc_dec, pc_inc};

endmodule

// File: tb/tb_xyz_peppergray_potato1_main.sv
// tb_xyz_peppergray_potato1_main
//
// Directed-vector bench for the Potato-1 control unit. Inputs are driven just
// after each rising edge and io_out is checked at the following falling edge,
// so each vector sees the state left by the previous one.

module tb_xyz_peppergray_potato1_main;

  logic       clock;
  logic       reset;
  logic       iowait;
  logic       zeroflag;
  logic [3:0] instruction;
  logic [7:0] io_in;
  logic [7:0] io_out;

  int tests_run;
  int tests_failed;

  assign io_in = {instruction, zeroflag, iowait, reset, clock};

  xyz_peppergray_potato1_main dut (
    .io_in  (io_in),
    .io_out (io_out)
  );

  // 10-unit clock period.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive one vector shortly after the next rising edge.
  task automatic applyStimulus(input logic rst, input logic [3:0] op,
                               input logic zf, input logic iow);
    @(posedge clock);
    #1;
    reset       = rst;
    instruction = op;
    zeroflag    = zf;
    iowait      = iow;
  endtask

  // Compare io_out against the expected value at the falling edge.
  task automatic checkOutput(input string tag, input logic [7:0] expected);
    @(negedge clock);
    tests_run++;
    if (io_out !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%02h expected 0x%02h", tag, io_out, expected);
    end
  endtask

  // Apply a vector and check its output in the same cycle.
  task automatic step(input string tag, input logic rst, input logic [3:0] op,
                      input logic zf, input logic iow, input logic [7:0] expected);
    applyStimulus(rst, op, zf, iow);
    checkOutput(tag, expected);
  endtask

  logic [3:0] decode_ops [8];
  logic [7:0] decode_exp [8];

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    instruction  = 4'h1;
    zeroflag     = 1'b0;
    iowait       = 1'b0;

    decode_ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hC};
    decode_exp = '{8'h01, 8'h11, 8'h21, 8'h05, 8'h09, 8'h41, 8'h81, 8'h01};

    // Reset held: outputs low whatever the inputs.
    checkOutput("reset_idle", 8'h00);
    step("reset_held_io", 1'b1, 4'h5, 1'b1, 1'b1, 8'h00);
    step("post_reset", 1'b0, 4'h1, 1'b0, 1'b0, 8'h11);

    // Straight-line decode.
    for (int i = 0; i < 8; i++) begin
      step($sformatf("decode_%0h", decode_ops[i]), 1'b0, decode_ops[i], 1'b0, 1'b0,
           decode_exp[i]);
    end

    // I/O stall on '.' then on ','.
    for (int i = 0; i < 3; i++) begin
      step($sformatf("put_stall_%0d", i), 1'b0, 4'h5, 1'b0, 1'b1, 8'h40);
    end
    step("put_release", 1'b0, 4'h5, 1'b0, 1'b0, 8'h41);
    step("get_stall", 1'b0, 4'h6, 1'b1, 1'b1, 8'h80);
    step("after_stall", 1'b0, 4'h1, 1'b0, 1'b0, 8'h11);

    // Forward skip, zeroflag/iowait toggled to show they are ignored in seek.
    step("fwd_open", 1'b0, 4'h7, 1'b1, 1'b0, 8'h01);
    step("fwd_plus", 1'b0, 4'h1, 1'b0, 1'b1, 8'h01);
    step("fwd_open2", 1'b0, 4'h7, 1'b1, 1'b0, 8'h01);
    step("fwd_close2", 1'b0, 4'h8, 1'b0, 1'b0, 8'h01);
    step("fwd_close1", 1'b0, 4'h8, 1'b1, 1'b0, 8'h01);
    step("fwd_exec", 1'b0, 4'h1, 1'b0, 1'b0, 8'h11);

    // Backward loop.
    step("back_close", 1'b0, 4'h8, 1'b0, 1'b0, 8'h02);
    step("back_minus", 1'b0, 4'h2, 1'b1, 1'b1, 8'h02);
    step("back_close2", 1'b0, 4'h8, 1'b1, 1'b0, 8'h02);
    step("back_open2", 1'b0, 4'h7, 1'b0, 1'b0, 8'h02);
    step("back_open1", 1'b0, 4'h7, 1'b0, 1'b0, 8'h01);
    step("back_exec", 1'b0, 4'h3, 1'b0, 1'b0, 8'h05);

    // Not-taken brackets stay in EXEC.
    step("open_not_taken", 1'b0, 4'h7, 1'b0, 1'b0, 8'h01);
    step("close_not_taken", 1'b0, 4'h8, 1'b1, 1'b0, 8'h01);
    step("not_taken_exec", 1'b0, 4'h2, 1'b0, 1'b0, 8'h21);

    // Reset mid-seek aborts the seek.
    step("seek_enter", 1'b0, 4'h7, 1'b1, 1'b0, 8'h01);
    step("seek_in_progress", 1'b0, 4'h1, 1'b0, 1'b0, 8'h01);
    step("reset_mid_seek", 1'b1, 4'h1, 1'b0, 1'b0, 8'h00);
    step("reset_mid_seek_hold", 1'b1, 4'h8, 1'b1, 1'b1, 8'h00);
    step("after_seek_reset", 1'b0, 4'h1, 1'b0, 1'b0, 8'h11);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
